// File: rtl/rob_pkg.sv
// Shared types for the multi-commit reorder buffer.
// ROB_EXCEPTION_EN adds a per-entry exception flag to rob_entry_t.
package rob_pkg;

    localparam int unsigned ROB_TYPE_W = 2;
    localparam int unsigned ROB_XLEN   = 32;

    typedef enum logic [ROB_TYPE_W-1:0] {
        ROB_REG    = 2'b00,
        ROB_LOAD   = 2'b01,
        ROB_STORE  = 2'b10,
        ROB_BRANCH = 2'b11
    } rob_type_e;

    typedef struct packed {
        logic                valid;
        logic                ready;
        logic                address_ready;
`ifdef ROB_EXCEPTION_EN
        logic                exception;
`endif
        rob_type_e           rtype;
        logic [ROB_XLEN-1:0] dest;
        logic [ROB_XLEN-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Picks which of the head entries retire this cycle: an in-order prefix of
// committable entries with at most one store per cycle.
// ROB_EXCEPTION_EN: an excepting entry is never committable.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2
) (
    input  rob_entry_t              head_entries [COMMIT_WIDTH],
    input  logic                    store_commit_ready,
    output logic [COMMIT_WIDTH-1:0] fire_c
);

    function automatic logic committable(input rob_entry_t e, input logic store_ok);
        logic ok;
        ok = e.valid && e.ready && e.address_ready;
`ifdef ROB_EXCEPTION_EN
        ok = ok && !e.exception;
`endif
        if (e.rtype == ROB_STORE) begin
            ok = ok && store_ok;
        end
        return ok;
    endfunction

    // Prefix chain: a slot fires only if every older slot fired.
    always_comb begin : select
        logic run;
        logic store_used;
        run        = 1'b1;
        store_used = 1'b0;
        fire_c     = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            run = run && committable(head_entries[k], store_commit_ready && !store_used);
            if (run && head_entries[k].rtype == ROB_STORE) begin
                store_used = 1'b1;
            end
            fire_c[k] = run;
        end
    end

endmodule

// File: rtl/reorder_buffer_mc.sv
// Circular in-order-retire reorder buffer with several CDB write ports,
// multi-entry commit and single-cycle squash on branch mispredict.
// Optional feature macro: ROB_EXCEPTION_EN (per-entry exception, buffer clear).
module reorder_buffer_mc
    import rob_pkg::*;
#(
    parameter int unsigned XLEN         = ROB_XLEN,
    parameter int unsigned BUF_SIZE     = 16,
    parameter int unsigned TAG_WIDTH    = 4,
    parameter int unsigned CDB_PORTS    = 2,
    parameter int unsigned COMMIT_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [ROB_TYPE_W-1:0]          dispatch_type,
    input  logic [XLEN-1:0]                dispatch_dest,
    input  logic [XLEN-1:0]                dispatch_value,
    input  logic                           dispatch_value_ready,
    output logic [TAG_WIDTH-1:0]           dispatch_tag,
    input  logic [CDB_PORTS-1:0]           cdb_valid,
    input  logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag,
    input  logic [CDB_PORTS*XLEN-1:0]      cdb_data,
`ifdef ROB_EXCEPTION_EN
    input  logic [CDB_PORTS-1:0]           cdb_exception,
    output logic                           exception_valid,
    output logic [TAG_WIDTH-1:0]           exception_tag,
`endif
    input  logic                           addr_valid,
    input  logic [TAG_WIDTH-1:0]           addr_tag,
    input  logic [XLEN-1:0]                addr_data,
    input  logic                           flush_valid,
    input  logic [TAG_WIDTH-1:0]           flush_tag,
    input  logic                           store_commit_ready,
    output logic [COMMIT_WIDTH-1:0]        commit_valid,
    output logic [COMMIT_WIDTH*ROB_TYPE_W-1:0] commit_type,
    output logic [COMMIT_WIDTH*XLEN-1:0]   commit_dest,
    output logic [COMMIT_WIDTH*XLEN-1:0]   commit_value,
    output logic [TAG_WIDTH:0]             count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PTR_W = TAG_WIDTH + 1;

    rob_entry_t              entries      [BUF_SIZE];
    rob_entry_t              head_entries [COMMIT_WIDTH];
    logic [PTR_W-1:0]        head, tail, head_next, tail_next, n_commit;
    logic [TAG_WIDTH-1:0]    head_idx, tail_idx, flush_dist;
    logic [COMMIT_WIDTH-1:0] fire_c;
    logic [BUF_SIZE-1:0]     retire_mask, squash_mask;
    logic                    do_dispatch, exc_fire;

    assign head_idx     = head[TAG_WIDTH-1:0];
    assign tail_idx     = tail[TAG_WIDTH-1:0];
    assign count        = tail - head;
    assign full         = (count == PTR_W'(BUF_SIZE));
    assign empty        = (count == '0);
    assign dispatch_tag = tail_idx;
    assign flush_dist   = flush_tag - head_idx;
    assign commit_valid = fire_c;

    // Exception at head clears the whole buffer; without the feature it never fires.
`ifdef ROB_EXCEPTION_EN
    assign exc_fire        = entries[head_idx].valid && entries[head_idx].ready
                             && entries[head_idx].exception;
    assign exception_valid = exc_fire;
    assign exception_tag   = head_idx;
`else
    assign exc_fire = 1'b0;
`endif

    assign dispatch_ready = !full && !flush_valid && !exc_fire;
    assign do_dispatch    = dispatch_valid && dispatch_ready;

    // Gather the oldest COMMIT_WIDTH entries and expose them on the commit ports.
    always_comb begin
        commit_type  = '0;
        commit_dest  = '0;
        commit_value = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            head_entries[k] = entries[TAG_WIDTH'(int'(head_idx) + k)];
            commit_type[k*ROB_TYPE_W +: ROB_TYPE_W] = head_entries[k].rtype;
            commit_dest[k*XLEN +: XLEN]             = XLEN'(head_entries[k].dest);
            commit_value[k*XLEN +: XLEN]            = XLEN'(head_entries[k].value);
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH(COMMIT_WIDTH)
    ) u_commit_select (
        .head_entries      (head_entries),
        .store_commit_ready(store_commit_ready),
        .fire_c            (fire_c)
    );

    // Retire/squash masks and next pointers.
    always_comb begin
        retire_mask = '0;
        squash_mask = '0;
        n_commit    = '0;
        for (int k = 0; k < int'(COMMIT_WIDTH); k++) begin
            n_commit = n_commit + PTR_W'(fire_c[k]);
            if (fire_c[k]) begin
                retire_mask[TAG_WIDTH'(int'(head_idx) + k)] = 1'b1;
            end
        end
        for (int i = 0; i < int'(BUF_SIZE); i++) begin
            if (flush_valid && (TAG_WIDTH'(TAG_WIDTH'(i) - head_idx) > flush_dist)) begin
                squash_mask[i] = 1'b1;
            end
        end
        head_next = head + n_commit;
        tail_next = tail + PTR_W'(do_dispatch);
        if (flush_valid) begin
            tail_next = head + PTR_W'(flush_dist) + PTR_W'(1);
        end
        if (exc_fire) begin
            head_next = tail;
            tail_next = tail;
        end
    end

    // Pointer and entry state: dispatch write, CDB/address updates, valid clears.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < int'(BUF_SIZE); i++) begin
                entries[i] <= '0;
            end
        end else begin
            head <= head_next;
            tail <= tail_next;
            for (int i = 0; i < int'(BUF_SIZE); i++) begin
                if (do_dispatch && tail_idx == TAG_WIDTH'(i)) begin
                    entries[i].valid         <= 1'b1;
                    entries[i].ready         <= dispatch_value_ready;
                    entries[i].address_ready <= (dispatch_type != ROB_STORE);
                    entries[i].rtype         <= rob_type_e'(dispatch_type);
                    entries[i].dest          <= ROB_XLEN'(dispatch_dest);
                    entries[i].value         <= ROB_XLEN'(dispatch_value);
`ifdef ROB_EXCEPTION_EN
                    entries[i].exception     <= 1'b0;
`endif
                end
                for (int p = 0; p < int'(CDB_PORTS); p++) begin
                    if (cdb_valid[p] && entries[i].valid
                        && cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] == TAG_WIDTH'(i)) begin
                        entries[i].value <= ROB_XLEN'(cdb_data[p*XLEN +: XLEN]);
                        entries[i].ready <= 1'b1;
`ifdef ROB_EXCEPTION_EN
                        entries[i].exception <= cdb_exception[p];
`endif
                    end
                end
                if (addr_valid && entries[i].valid && entries[i].rtype == ROB_STORE
                    && addr_tag == TAG_WIDTH'(i)) begin
                    entries[i].dest          <= ROB_XLEN'(addr_data);
                    entries[i].address_ready <= 1'b1;
                end
                if (retire_mask[i] || squash_mask[i] || exc_fire) begin
                    entries[i].valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc with a commit scoreboard.
// Build with ROB_EXCEPTION_EN to also exercise the exception path.
module tb_reorder_buffer_mc;
    import rob_pkg::*;

    localparam int unsigned XLEN = 32, TAG_WIDTH = 4, CDB_PORTS = 2, COMMIT_WIDTH = 2;

    logic clk = 1'b0;
    logic reset;
    logic dispatch_valid, dispatch_ready, dispatch_value_ready;
    logic [1:0] dispatch_type;
    logic [XLEN-1:0] dispatch_dest, dispatch_value;
    logic [TAG_WIDTH-1:0] dispatch_tag;
    logic [CDB_PORTS-1:0] cdb_valid;
    logic [CDB_PORTS*TAG_WIDTH-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0] cdb_data;
`ifdef ROB_EXCEPTION_EN
    logic [CDB_PORTS-1:0] cdb_exception;
    logic exception_valid;
    logic [TAG_WIDTH-1:0] exception_tag;
`endif
    logic addr_valid;
    logic [TAG_WIDTH-1:0] addr_tag;
    logic [XLEN-1:0] addr_data;
    logic flush_valid;
    logic [TAG_WIDTH-1:0] flush_tag;
    logic store_commit_ready;
    logic [COMMIT_WIDTH-1:0] commit_valid;
    logic [COMMIT_WIDTH*2-1:0] commit_type;
    logic [COMMIT_WIDTH*XLEN-1:0] commit_dest, commit_value;
    logic [TAG_WIDTH:0] count;
    logic full, empty;

    typedef struct {
        logic [1:0]      t;
        logic [XLEN-1:0] dest;
        logic [XLEN-1:0] value;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    reorder_buffer_mc dut (
        .clk(clk), .reset(reset),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_type(dispatch_type), .dispatch_dest(dispatch_dest),
        .dispatch_value(dispatch_value), .dispatch_value_ready(dispatch_value_ready),
        .dispatch_tag(dispatch_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
`ifdef ROB_EXCEPTION_EN
        .cdb_exception(cdb_exception), .exception_valid(exception_valid),
        .exception_tag(exception_tag),
`endif
        .addr_valid(addr_valid), .addr_tag(addr_tag), .addr_data(addr_data),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .store_commit_ready(store_commit_ready),
        .commit_valid(commit_valid), .commit_type(commit_type),
        .commit_dest(commit_dest), .commit_value(commit_value),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dispatch_valid = 1'b0;
        cdb_valid      = '0;
        addr_valid     = 1'b0;
        flush_valid    = 1'b0;
`ifdef ROB_EXCEPTION_EN
        cdb_exception  = '0;
`endif
    endtask

    task automatic disp(input logic [1:0] t, input logic [31:0] d, input logic [31:0] v,
                        input logic vr);
        dispatch_valid       = 1'b1;
        dispatch_type        = t;
        dispatch_dest        = d;
        dispatch_value       = v;
        dispatch_value_ready = vr;
    endtask

    task automatic cdb(input int p, input logic [3:0] tag, input logic [31:0] data);
        cdb_valid[p]                 = 1'b1;
        cdb_tag[p*TAG_WIDTH +: TAG_WIDTH] = tag;
        cdb_data[p*XLEN +: XLEN]     = data;
    endtask

    task automatic addr(input logic [3:0] tag, input logic [31:0] a);
        addr_valid = 1'b1;
        addr_tag   = tag;
        addr_data  = a;
    endtask

    task automatic flush(input logic [3:0] tag);
        flush_valid = 1'b1;
        flush_tag   = tag;
    endtask

    task automatic push(input logic [1:0] t, input logic [31:0] d, input logic [31:0] v);
        exp_t e;
        e.t = t; e.dest = d; e.value = v;
        sb.push_back(e);
    endtask

    // Check this cycle's retirements against the scoreboard, then advance one clock.
    task automatic step(input int n);
        logic [COMMIT_WIDTH-1:0] mask;
        exp_t e;
        #1;
        mask = COMMIT_WIDTH'((1 << n) - 1);
        chk("commit_valid", 64'(commit_valid), 64'(mask));
        for (int k = 0; k < n; k++) begin
            chk("sb_avail", 64'(sb.size() > 0), 64'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("commit_type",  64'(commit_type[k*2 +: 2]),        64'(e.t));
                chk("commit_dest",  64'(commit_dest[k*XLEN +: XLEN]),  64'(e.dest));
                chk("commit_value", 64'(commit_value[k*XLEN +: XLEN]), 64'(e.value));
            end
        end
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        dispatch_type = '0; dispatch_dest = '0; dispatch_value = '0;
        dispatch_value_ready = 1'b0; cdb_tag = '0; cdb_data = '0;
        addr_tag = '0; addr_data = '0; flush_tag = '0; store_commit_ready = 1'b1;

        // Reset state, fill to full, overflow dispatch, no-op flush, 2-wide commit.
        do_reset();
        #1;
        chk("rst_commit_valid", 64'(commit_valid), 64'(0));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_dispatch_ready", 64'(dispatch_ready), 64'(1));
        chk("rst_dispatch_tag", 64'(dispatch_tag), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        for (int i = 0; i < 16; i++) begin
            disp(ROB_REG, 32'h20 + 32'(i), 32'h0, 1'b0);
            #1;
            chk("fill_tag", 64'(dispatch_tag), 64'(i));
            step(0);
        end
        chk("full_count", 64'(count), 64'(16));
        chk("full_flag", 64'(full), 64'(1));
        chk("full_dispatch_ready", 64'(dispatch_ready), 64'(0));
        disp(ROB_REG, 32'h99, 32'h99, 1'b1);
        step(0);
        chk("overflow_count", 64'(count), 64'(16));
        flush(4'd15);
        #1;
        chk("flush_dispatch_ready", 64'(dispatch_ready), 64'(0));
        step(0);
        chk("full_flush_count", 64'(count), 64'(16));
        chk("full_flush_full", 64'(full), 64'(1));
        cdb(0, 4'd1, 32'hA);
        step(0);
        cdb(0, 4'd0, 32'hB);
        step(0);
        push(ROB_REG, 32'h20, 32'hB);
        push(ROB_REG, 32'h21, 32'hA);
        step(2);
        chk("after_commit_count", 64'(count), 64'(14));

        // Stores: wait for address, one store per cycle, store_commit_ready gating.
        do_reset();
        store_commit_ready = 1'b1;
        disp(ROB_REG, 32'h30, 32'h0, 1'b0);    step(0);
        disp(ROB_REG, 32'h31, 32'h0, 1'b0);    step(0);
        disp(ROB_REG, 32'h32, 32'h0, 1'b0);    step(0);
        disp(ROB_STORE, 32'hFFFF, 32'h0, 1'b0); step(0);
        disp(ROB_STORE, 32'hFFFF, 32'h44, 1'b1); step(0);
        disp(ROB_STORE, 32'hFFFF, 32'h55, 1'b1); step(0);
        cdb(0, 4'd0, 32'hA0); cdb(1, 4'd1, 32'hA1); addr(4'd0, 32'hDEAD);
        step(0);
        cdb(0, 4'd2, 32'hA2); cdb(1, 4'd3, 32'h33); addr(4'd4, 32'h200);
        push(ROB_REG, 32'h30, 32'hA0); push(ROB_REG, 32'h31, 32'hA1);
        step(2);
        addr(4'd5, 32'h300);
        push(ROB_REG, 32'h32, 32'hA2);
        step(1);
        addr(4'd3, 32'h100);
        step(0);
        push(ROB_STORE, 32'h100, 32'h33);
        step(1);
        store_commit_ready = 1'b0;
        step(0);
        store_commit_ready = 1'b1;
        push(ROB_STORE, 32'h200, 32'h44);
        step(1);
        push(ROB_STORE, 32'h300, 32'h55);
        step(1);
        chk("store_empty", 64'(empty), 64'(1));

        // Wrap-around and flush across the index boundary; squashed CDB write dropped.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            disp(ROB_REG, 32'h40 + 32'(i), 32'h100 + 32'(i), 1'b1);
            if (i > 0) push(ROB_REG, 32'h40 + 32'(i - 1), 32'h100 + 32'(i - 1));
            step(i > 0 ? 1 : 0);
        end
        push(ROB_REG, 32'h4D, 32'h10D);
        step(1);
        chk("wrap_empty", 64'(empty), 64'(1));
        for (int i = 0; i < 4; i++) begin
            disp(ROB_REG, 32'h50 + 32'(i), 32'h0, 1'b0);
            #1;
            chk("wrap_tag", 64'(dispatch_tag), 64'((14 + i) % 16));
            step(0);
        end
        chk("wrap_count", 64'(count), 64'(4));
        flush(4'd15);
        cdb(0, 4'd0, 32'h77);
        step(0);
        chk("wrap_flush_count", 64'(count), 64'(2));
        chk("wrap_flush_tail", 64'(dispatch_tag), 64'(0));
        cdb(0, 4'd14, 32'hE); cdb(1, 4'd15, 32'hF);
        step(0);
        push(ROB_REG, 32'h50, 32'hE); push(ROB_REG, 32'h51, 32'hF);
        step(2);
        step(0);
        step(0);
        chk("wrap_final_empty", 64'(empty), 64'(1));

        // Flush with a committable branch at head and a blocked same-cycle dispatch.
        do_reset();
        disp(ROB_BRANCH, 32'h60, 32'h0, 1'b0); step(0);
        disp(ROB_REG, 32'h61, 32'h0, 1'b0);    step(0);
        disp(ROB_REG, 32'h62, 32'h0, 1'b0);    step(0);
        cdb(0, 4'd0, 32'hB1);
        step(0);
        flush(4'd0);
        disp(ROB_REG, 32'h70, 32'h70, 1'b1);
        #1;
        chk("br_dispatch_ready", 64'(dispatch_ready), 64'(0));
        push(ROB_BRANCH, 32'h60, 32'hB1);
        step(1);
        chk("br_empty", 64'(empty), 64'(1));
        chk("br_count", 64'(count), 64'(0));
        chk("br_tail", 64'(dispatch_tag), 64'(1));
        step(0);

`ifdef ROB_EXCEPTION_EN
        // Exception at head: older entries retire, then the buffer is cleared.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            disp(ROB_REG, 32'h80 + 32'(i), 32'h0, 1'b0);
            step(0);
        end
        cdb(0, 4'd0, 32'hC0); cdb(1, 4'd1, 32'hC1);
        step(0);
        cdb(0, 4'd2, 32'hC2); cdb_exception[0] = 1'b1;
        push(ROB_REG, 32'h80, 32'hC0); push(ROB_REG, 32'h81, 32'hC1);
        step(2);
        #1;
        chk("exc_valid", 64'(exception_valid), 64'(1));
        chk("exc_tag", 64'(exception_tag), 64'(2));
        step(0);
        chk("exc_empty", 64'(empty), 64'(1));
        chk("exc_count", 64'(count), 64'(0));
        chk("exc_pulse_end", 64'(exception_valid), 64'(0));
`endif

        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
